// File: rtl/adc_capture_window.sv
// Circular capture of the ADC sample stream around a trigger rising edge.
// The frozen window is streamed oldest-first over a valid/ready handshake.
module adc_capture_window #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned PRE   = 32,
    localparam int unsigned DW   = 14,
    localparam int unsigned CW   = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] adc_in,
    input  logic          trigger,
    input  logic          arm,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic [CW-1:0] trig_count
);

    localparam int unsigned   RW        = AW + 1;
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE - 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(DEPTH - 1);
    localparam logic [RW-1:0] RD_END    = RW'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_pre_cnt;
    logic [AW-1:0] r_post_cnt;
    logic [RW-1:0] r_rd_cnt;
    logic          r_trig_d;
    logic          r_q_vld;
    logic          r_q_last;
    logic [DW-1:0] r_ram_q;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_busy;
    logic [CW-1:0] r_trig_count;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_rise;
    logic w_we;
    logic w_fire;
    logic w_load;
    logic w_issue;

    assign w_rise  = trigger & ~r_trig_d;
    assign w_we    = (r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_fire  = r_out_valid & out_ready;
    // RAM output stage acts as the prefetch slot ahead of the output register
    assign w_load  = r_q_vld & (~r_out_valid | out_ready);
    assign w_issue = (r_state == S_READOUT) && (r_rd_cnt != RD_END) && (!r_q_vld || w_load);

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign trig_count = r_trig_count;

    // Sample RAM: write while recording, synchronous read during readout
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= adc_in;
        end
        if (w_issue) begin
            r_ram_q <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_rd_cnt     <= '0;
            r_trig_d     <= 1'b0;
            r_q_vld      <= 1'b0;
            r_q_last     <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_trig_count <= '0;
        end else begin
            r_trig_d <= trigger;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state   <= S_FILL;
                        r_pre_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_FILL: begin
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                    r_pre_cnt <= r_pre_cnt + AW'(1);
                    if (r_pre_cnt == PRE_LAST) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    if (w_rise) begin
                        r_post_cnt <= POST_INIT;
                        r_state    <= S_POST;
                    end
                end
                S_POST: begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_post_cnt <= r_post_cnt - AW'(1);
                    // After this write the slot following it holds the oldest sample
                    if (r_post_cnt == AW'(1)) begin
                        r_state  <= S_READOUT;
                        r_rd_ptr <= r_wr_ptr + AW'(1);
                        r_rd_cnt <= '0;
                        if (r_trig_count != CNT_MAX) begin
                            r_trig_count <= r_trig_count + CW'(1);
                        end
                    end
                end
                S_READOUT: begin
                    if (w_issue) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                        r_rd_cnt <= r_rd_cnt + RW'(1);
                        r_q_vld  <= 1'b1;
                        r_q_last <= (r_rd_cnt == RD_LAST);
                    end else if (w_load) begin
                        r_q_vld <= 1'b0;
                    end
                    if (w_load) begin
                        r_out_data  <= r_ram_q;
                        r_out_last  <= r_q_last;
                        r_out_valid <= 1'b1;
                    end else if (w_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                    if (w_fire && r_out_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_window.sv
// Directed bench for adc_capture_window with DEPTH=16, PRE=4 and a counter as ADC input.
module tb_adc_capture_window;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned PRE   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] adc_in;
    logic        trigger;
    logic        arm;
    logic [13:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [15:0] trig_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) adc_in <= '0;
        else          adc_in <= adc_in + 14'd1;
    end

    adc_capture_window #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .PRE  (PRE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .adc_in    (adc_in),
        .trigger   (trigger),
        .arm       (arm),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .trig_count(trig_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge where adc_in == v
    task automatic wait_adc(input logic [13:0] v);
        int n = 0;
        while (adc_in !== v && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_adc", 32'(adc_in), 32'(v));
    endtask

    task automatic arm_at(input logic [13:0] v);
        wait_adc(v);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic trig_at(input logic [13:0] v);
        wait_adc(v);
        trigger = 1'b1;
        wait_adc(14'(v + 14'd3));
        trigger = 1'b0;
    endtask

    task automatic reset_checked(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_rst_busy"},  32'(busy),      32'(0));
        chk({tag, "_rst_last"},  32'(out_last),  32'(0));
        chk({tag, "_rst_data"},  32'(out_data),  32'(0));
        chk({tag, "_rst_count"}, 32'(trig_count), 32'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // pat 0: always ready; pat 1: ready pattern 1,0,0,1 repeating
    task automatic collect(input logic [13:0] first, input int pat, input int max_xfer,
                           input bit arm_hold, input string tag);
        int  idx = 0;
        int  k   = 0;
        bit  r;
        while (idx < max_xfer && k < 400) begin
            r = (pat == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            out_ready = r;
            arm       = arm_hold;
            if (out_valid) begin
                chk({tag, "_data"}, 32'(out_data), 32'(14'(first + 14'(idx))));
                chk({tag, "_last"}, 32'(out_last), 32'(idx == int'(DEPTH) - 1));
                if (r) idx++;
            end
            @(negedge clk);
            k++;
        end
        arm       = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_xfers"}, 32'(idx), 32'(max_xfer));
        if (max_xfer == int'(DEPTH)) begin
            chk({tag, "_valid_after"}, 32'(out_valid), 32'(0));
            chk({tag, "_busy_after"},  32'(busy),      32'(0));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        arm       = 1'b0;
        trigger   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_checked("init");

        // Basic capture with first-valid latency
        arm_at(14'd10);
        wait_adc(14'd20);
        chk("basic_busy_armed", 32'(busy), 32'(1));
        trig_at(14'd50);
        wait_adc(14'd62);
        chk("basic_lat62", 32'(out_valid), 32'(0));
        chk("basic_cnt_entry", 32'(trig_count), 32'(1));
        @(negedge clk);
        chk("basic_lat63", 32'(out_valid), 32'(0));
        @(negedge clk);
        chk("basic_lat64", 32'(out_valid), 32'(1));
        collect(14'd46, 0, 16, 1'b0, "basic");
        chk("basic_count", 32'(trig_count), 32'(1));

        // Trigger pulse during FILL is ignored
        reset_checked("fill");
        arm_at(14'd10);
        wait_adc(14'd12);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_adc(14'd25);
        chk("fill_busy", 32'(busy), 32'(1));
        chk("fill_novalid", 32'(out_valid), 32'(0));
        chk("fill_nocount", 32'(trig_count), 32'(0));
        trig_at(14'd30);
        collect(14'd26, 0, 16, 1'b0, "fill");
        chk("fill_count", 32'(trig_count), 32'(1));

        // Trigger already high when armed needs a fresh rising edge
        reset_checked("held");
        trigger = 1'b1;
        arm_at(14'd10);
        wait_adc(14'd39);
        chk("held_busy", 32'(busy), 32'(1));
        chk("held_novalid", 32'(out_valid), 32'(0));
        chk("held_nocount", 32'(trig_count), 32'(0));
        wait_adc(14'd40);
        trigger = 1'b0;
        trig_at(14'd45);
        collect(14'd41, 0, 16, 1'b0, "held");
        chk("held_count", 32'(trig_count), 32'(1));

        // Backpressure
        reset_checked("bp");
        arm_at(14'd10);
        trig_at(14'd50);
        collect(14'd46, 1, 16, 1'b0, "bp");
        chk("bp_count", 32'(trig_count), 32'(1));

        // Reset in the middle of readout, then a normal capture
        reset_checked("mid0");
        arm_at(14'd10);
        trig_at(14'd50);
        collect(14'd46, 0, 7, 1'b0, "mid");
        chk("mid_valid_before", 32'(out_valid), 32'(1));
        reset_checked("mid");
        arm_at(14'd10);
        trig_at(14'd50);
        collect(14'd46, 0, 16, 1'b0, "mid_again");
        chk("mid_again_count", 32'(trig_count), 32'(1));

        // Saturation, and arm held throughout readout including the final transfer
        reset_checked("sat");
        force dut.r_trig_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_trig_count;
        @(negedge clk);
        chk("sat_preload", 32'(trig_count), 32'(16'hFFFF));
        arm_at(14'd10);
        trig_at(14'd50);
        collect(14'd46, 0, 16, 1'b1, "sat");
        chk("sat_count", 32'(trig_count), 32'(16'hFFFF));
        repeat (4) @(negedge clk);
        chk("sat_idle_busy",  32'(busy),      32'(0));
        chk("sat_idle_valid", 32'(out_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
